// File: rtl/fft_pipe_pkg.sv
// fft_pipe_pkg: shared defaults, state type and lane helpers for the FFT output pipe
package fft_pipe_pkg;
  localparam int D_WIDTH_DEF = 64;
  localparam int LANES_DEF = 16;
  localparam int LANE_W = $clog2(LANES_DEF);
  typedef enum logic {EMPTY, BUSY} state_t;
  function automatic int bitrev(input int v, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++) r = r | (((v >> i) & 1) << (w - 1 - i));
    return r;
  endfunction
  function automatic int lane_lo(input int k, input int dw);
    return k * dw;
  endfunction
endpackage

// File: rtl/fft_lane_sel.sv
// fft_lane_sel: combinational LANES:1 mux picking one D_WIDTH-bit lane of a parallel word
// data: LANES*D_WIDTH packed lanes (lane k at [k*D_WIDTH +: D_WIDTH]); sel: lane number; y: selected lane
module fft_lane_sel
  import fft_pipe_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic [LANES*D_WIDTH-1:0]   data,
  input  logic [$clog2(LANES)-1:0]   sel,
  output logic [D_WIDTH-1:0]         y
);
  always_comb y = data[lane_lo(int'(sel), D_WIDTH) +: D_WIDTH];
endmodule

// File: rtl/fft_lane_serializer.sv
// fft_lane_serializer: drains LANES-lane parallel words into a D_WIDTH sample stream, one lane per cycle
// clk, rst_n (sync, active-low); in_valid/in_ready/in_data: parallel word input;
// out_valid/out_ready/out_data/out_idx/out_last: serial sample output.
// FFT_SER_BITREV_EN defined: lanes leave in bit-reversed order; undefined: natural order.
module fft_lane_serializer
  import fft_pipe_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*D_WIDTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [D_WIDTH-1:0]         out_data,
  output logic [$clog2(LANES)-1:0]   out_idx,
  output logic                       out_last
);
  localparam int LW = $clog2(LANES);
  state_t state, state_n;
  logic [LW-1:0] cnt, cnt_n, lane;
  logic [LANES*D_WIDTH-1:0] hold;
  logic [D_WIDTH-1:0] sel_data;
  logic last, in_hs, out_hs;
  assign last = cnt == LW'(LANES - 1);
  assign in_hs = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
`ifdef FFT_SER_BITREV_EN
  assign lane = LW'(bitrev(int'(cnt), LW));
`else
  assign lane = cnt;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_ff @(posedge clk) if (in_hs) hold <= in_data;
  // cnt wraps to zero on the last beat, so an EMPTY return leaves it ready for the next word
  always_comb begin
    state_n = in_hs ? BUSY : (out_hs && last) ? EMPTY : state;
    cnt_n = in_hs ? '0 : cnt + LW'(out_hs);
  end
  // out_data is forced to zero while EMPTY so no stale lane is ever visible
  always_comb begin
    out_valid = state == BUSY;
    in_ready = rst_n & (!out_valid | (out_ready & last));
    out_data = out_valid ? sel_data : '0;
    out_idx = lane;
    out_last = out_valid & last;
  end
  fft_lane_sel #(.D_WIDTH(D_WIDTH), .LANES(LANES)) u_sel (
    .data(hold),
    .sel(lane),
    .y(sel_data)
  );
endmodule

// File: tb/tb_fft_lane_serializer.sv
// tb_fft_lane_serializer: directed and randomized checks of fft_lane_serializer against a beat-queue model
module tb_fft_lane_serializer;
  localparam int DW = 64;
  localparam int N = 16;
  localparam int LW = 4;
`ifdef FFT_SER_BITREV_EN
  localparam int L1 = 8;
  localparam int L5 = 10;
`else
  localparam int L1 = 1;
  localparam int L5 = 5;
`endif
  typedef struct {logic [63:0] d; int idx; bit last;} beat_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [N*DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_idx;
  beat_t q[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  fft_lane_serializer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last)
  );
  function automatic int lane_of(input int b);
`ifdef FFT_SER_BITREV_EN
    int r, t;
    r = 0;
    t = b;
    repeat (LW) begin
      r = r * 2 + t % 2;
      t = t / 2;
    end
    return r;
`else
    return b;
`endif
  endfunction
  function automatic logic [N*DW-1:0] mkword(input logic [63:0] base);
    logic [N*DW-1:0] w;
    for (int k = 0; k < N; k++) w[k*DW +: DW] = base + 64'(k);
    return w;
  endfunction
  function automatic bit exp_ready();
    return rst_n && (q.size() == 0 || (q.size() == 1 && out_ready));
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    if (!rst_n) q.delete();
    else if (in_valid && exp_ready()) begin
      if (q.size() != 0) void'(q.pop_front());
      for (int b = 0; b < N; b++)
        q.push_back('{d: in_data[lane_of(b)*DW +: DW], idx: lane_of(b), last: b == N - 1});
    end else if (q.size() != 0 && out_ready) void'(q.pop_front());
  end
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(exp_ready()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_idx", 64'(out_idx), 64'(q[0].idx));
      chk("out_last", 64'(out_last), 64'(q[0].last));
    end else begin
      chk("idle_data", out_data, 64'd0);
      chk("idle_last", 64'(out_last), 64'd0);
    end
  end
  initial begin
    bit acc;
    repeat (3) step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    repeat (5) step();
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    // single word
    out_ready = 1;
    in_data = mkword(64'h1000);
    in_valid = 1;
    step();
    in_valid = 0;
    chk("w_beat0_data", out_data, 64'h1000);
    chk("w_beat0_idx", 64'(out_idx), 64'd0);
    step();
    chk("w_beat1_idx", 64'(out_idx), 64'(L1));
    chk("w_beat1_data", out_data, 64'h1000 + 64'(L1));
    repeat (14) step();
    chk("w_last", 64'(out_last), 64'd1);
    chk("w_last_idx", 64'(out_idx), 64'd15);
    chk("w_last_data", out_data, 64'h100F);
    step();
    chk("w_done", 64'(out_valid), 64'd0);
    // back-to-back
    in_data = mkword(64'h2000);
    in_valid = 1;
    step();
    in_data = mkword(64'h3000);
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        chk("b2b_a_last", 64'(out_last), 64'd1);
        step();
        acc = 1;
        break;
      end
      step();
    end
    in_valid = 0;
    chk("b2b_accept", 64'(acc), 64'd1);
    chk("b2b_b_valid", 64'(out_valid), 64'd1);
    chk("b2b_b_data", out_data, 64'h3000);
    repeat (16) step();
    chk("b2b_done", 64'(out_valid), 64'd0);
    // backpressure at beat 5
    in_data = mkword(64'h1000);
    in_valid = 1;
    step();
    in_valid = 0;
    repeat (5) step();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_data", out_data, 64'h1000 + 64'(L5));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1;
    step();
    chk("bp_resume", out_data, 64'h1006);
    repeat (10) step();
    chk("bp_done", 64'(out_valid), 64'd0);
    // reset mid-word at beat 7
    in_data = mkword(64'h1000);
    in_valid = 1;
    step();
    in_valid = 0;
    repeat (7) step();
    chk("mid_beat7", 64'(out_valid), 64'd1);
    rst_n = 0;
    step();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    rst_n = 1;
    #1;
    chk("mid_rel_ready", 64'(in_ready), 64'd1);
    in_data = mkword(64'h4000);
    in_valid = 1;
    step();
    in_valid = 0;
    chk("mid_new_data", out_data, 64'h4000);
    chk("mid_new_idx", 64'(out_idx), 64'd0);
    repeat (16) step();
    chk("mid_done", 64'(out_valid), 64'd0);
    // random traffic, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom % 2);
      out_ready = $urandom_range(0, 3) != 0;
      in_data = mkword({32'($urandom), 32'($urandom)});
      step();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (40) step();
    chk("rand_drain", 64'(out_valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
